// File: rtl/alu_8bit_pkg.sv
// Shared definitions for the registered 8-bit ALU: datapath width and opcode encoding.
package alu_8bit_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } opcode_e;

endpackage

// File: rtl/alu_8bit_comb.sv
// Purely combinational ALU core: opcode decode plus result and flag generation.
module alu_8bit_comb
  import alu_8bit_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  opcode_e           opcode,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              overflow
);

  logic [DATA_W:0] wide;

  // Compute the result and carry/overflow for the selected operation; a 9-bit
  // intermediate gives the carry-out on add and the borrow on subtract.
  always_comb begin
    wide     = '0;
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (opcode)
      OP_ADD: begin
        wide     = {1'b0, a} + {1'b0, b};
        result   = wide[DATA_W-1:0];
        carry    = wide[DATA_W];
        overflow = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        wide     = {1'b0, a} - {1'b0, b};
        result   = wide[DATA_W-1:0];
        carry    = wide[DATA_W];
        overflow = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        carry  = a[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        carry  = a[0];
      end
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_8bit_sync.sv
// Registered 8-bit ALU: wraps the combinational core with output registers and a valid pipeline.
module alu_8bit_sync
  import alu_8bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [2:0]        Opcode,
  output logic              out_valid,
  output logic [DATA_W-1:0] Result,
  output logic              Carry,
  output logic              Zero,
  output logic              Overflow
);

  logic [DATA_W-1:0] nextResult;
  logic              nextCarry;
  logic              nextZero;
  logic              nextOverflow;

  alu_8bit_comb u_comb (
    .a        (A),
    .b        (B),
    .opcode   (opcode_e'(Opcode)),
    .result   (nextResult),
    .carry    (nextCarry),
    .zero     (nextZero),
    .overflow (nextOverflow)
  );

  // Capture results only on accepted operations so outputs hold otherwise; reset wins over in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Result    <= '0;
      Carry     <= 1'b0;
      Zero      <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Result   <= nextResult;
        Carry    <= nextCarry;
        Zero     <= nextZero;
        Overflow <= nextOverflow;
      end
    end
  end

endmodule

// File: tb/tb_alu_8bit_sync.sv
// Scoreboard testbench for alu_8bit_sync: expected results are queued on drive and compared on out_valid.
module tb_alu_8bit_sync;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       v;
  } expT;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] Opcode;
  logic       out_valid;
  logic [7:0] Result;
  logic       Carry;
  logic       Zero;
  logic       Overflow;

  expT sb[$];
  expT held;
  logic expValid;
  int vectors;
  int miscompares;

  alu_8bit_sync dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Opcode    (Opcode),
    .out_valid (out_valid),
    .Result    (Result),
    .Carry     (Carry),
    .Zero      (Zero),
    .Overflow  (Overflow)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built from integer arithmetic and signed range checks.
  function automatic expT model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    expT e;
    int s;
    int ss;
    e = '0;
    s = 0;
    ss = 0;
    case (op)
      3'b000: begin
        s = int'(a) + int'(b);
        e.res = s[7:0];
        e.c = (s > 255);
        ss = int'($signed(a)) + int'($signed(b));
        e.v = (ss > 127) || (ss < -128);
      end
      3'b001: begin
        s = int'(a) - int'(b);
        e.res = s[7:0];
        e.c = (a < b);
        ss = int'($signed(a)) - int'($signed(b));
        e.v = (ss > 127) || (ss < -128);
      end
      3'b010: e.res = a & b;
      3'b011: e.res = a | b;
      3'b100: e.res = a ^ b;
      3'b101: e.res = ~a;
      3'b110: begin
        e.res = a << 1;
        e.c = a[7];
      end
      default: begin
        e.res = a >> 1;
        e.c = a[0];
      end
    endcase
    e.z = (e.res == 8'h00);
    return e;
  endfunction

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at time %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare DUT outputs after an edge against the scoreboard or the held values.
  task automatic checkCycle();
    checkOutput("out_valid", {7'd0, out_valid}, {7'd0, expValid});
    if (out_valid || expValid) begin
      checkOutput("sb_depth", 8'(sb.size()), 8'd1);
      if (sb.size() > 0) held = sb.pop_front();
    end
    checkOutput("Result", Result, held.res);
    checkOutput("Carry", {7'd0, Carry}, {7'd0, held.c});
    checkOutput("Zero", {7'd0, Zero}, {7'd0, held.z});
    checkOutput("Overflow", {7'd0, Overflow}, {7'd0, held.v});
  endtask

  // Drive one cycle of inputs, update the expectations, then check after the edge.
  task automatic applyStimulus(input logic rstV, input logic validV, input logic [7:0] a,
                               input logic [7:0] b, input logic [2:0] op);
    rst = rstV;
    in_valid = validV;
    A = a;
    B = b;
    Opcode = op;
    if (rstV) begin
      expValid = 1'b0;
      held = '0;
    end else if (validV) begin
      sb.push_back(model(a, b, op));
      expValid = 1'b1;
    end else begin
      expValid = 1'b0;
    end
    @(negedge clk);
    checkCycle();
  endtask

  // Directed cases from the test plan, then a randomized stream with idles and a reset.
  initial begin
    vectors = 0;
    miscompares = 0;
    held = '0;
    expValid = 1'b0;

    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 3'b000);
    applyStimulus(1'b1, 1'b1, 8'h12, 8'h34, 3'b000);

    applyStimulus(1'b0, 1'b1, 8'd10, 8'd20, 3'b000);
    applyStimulus(1'b0, 1'b1, 8'd127, 8'd1, 3'b000);
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'h01, 3'b000);
    applyStimulus(1'b0, 1'b1, 8'd10, 8'd20, 3'b001);
    applyStimulus(1'b0, 1'b1, 8'h80, 8'h01, 3'b001);
    applyStimulus(1'b0, 1'b1, 8'hAA, 8'h55, 3'b010);
    applyStimulus(1'b0, 1'b1, 8'hAA, 8'h55, 3'b011);
    applyStimulus(1'b0, 1'b1, 8'hAA, 8'h55, 3'b100);
    applyStimulus(1'b0, 1'b1, 8'hAA, 8'h55, 3'b101);
    applyStimulus(1'b0, 1'b1, 8'h0F, 8'h00, 3'b110);
    applyStimulus(1'b0, 1'b1, 8'h0F, 8'h00, 3'b111);
    applyStimulus(1'b0, 1'b1, 8'h80, 8'h00, 3'b110);

    applyStimulus(1'b0, 1'b0, 8'h33, 8'h44, 3'b000);
    applyStimulus(1'b0, 1'b0, 8'h01, 8'h01, 3'b011);

    applyStimulus(1'b0, 1'b1, 8'h7F, 8'h80, 3'b001);
    applyStimulus(1'b1, 1'b1, 8'h01, 8'h02, 3'b000);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 3'b000);

    for (int i = 0; i < 200; i++) begin
      applyStimulus(i == 120, $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                    3'($urandom_range(0, 7)));
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
